// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
//   - 4-bit operation codes (ALU_AND .. ALU_REMU)
//   - state encoding of the multiply/divide sequencer
//   - is_muldiv(): true for codes that use the multi-cycle datapath
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLTS  = 4'b1011;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_MULHU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  // The four multiply/divide codes share the 11xx prefix.
  function automatic logic is_muldiv(input logic [3:0] code);
    return (code[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply / unsigned divide engine.
// One shift-add (multiply) or restoring (divide) step per cycle, WIDTH steps.
// The final step is presented combinationally on lo/hi together with done, so
// the parent can capture the answer on the same edge the last step would occur.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   go          start an operation (only honoured while idle)
//   op          0 = multiply, 1 = divide
//   a, b        operands, sampled when go is accepted
//   done        high in the cycle whose edge completes the operation
//   lo, hi      multiply: low/high product halves; divide: quotient/remainder
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state_r;
  logic [SHW-1:0]     cnt_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   rem_r;

  logic [WIDTH:0]     psum_s;
  logic [2*WIDTH-1:0] prod_nx_s;
  logic [WIDTH:0]     shft_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   quo_nx_s;
  logic [WIDTH-1:0]   rem_nx_s;

  // Next-step values for both datapaths.
  always_comb begin
    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift {carry, high, low} right by one.
    if (prod_r[0]) begin
      psum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
    end else begin
      psum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
    prod_nx_s = {psum_s, prod_r[WIDTH-1:1]};

    // Restoring divide: bring in the next dividend bit, keep the difference
    // only when it did not borrow.
    shft_s = {rem_r, quo_r[WIDTH-1]};
    diff_s = shft_s - {1'b0, opb_r};
    if (!diff_s[WIDTH]) begin
      rem_nx_s = diff_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_s = shft_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Completion flag and final-step result selection.
  always_comb begin
    done = (state_r != ST_IDLE) && (cnt_r == {SHW{1'b0}});
    if (state_r == ST_MUL) begin
      lo = prod_nx_s[WIDTH-1:0];
      hi = prod_nx_s[2*WIDTH-1:WIDTH];
    end else begin
      lo = quo_nx_s;
      hi = rem_nx_s;
    end
  end

  // Sequencer: operand capture, per-cycle step and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {SHW{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            state_r <= op ? ST_DIV : ST_MUL;
            cnt_r   <= SHW'(WIDTH - 1);
            prod_r  <= {{WIDTH{1'b0}}, a};
            opb_r   <= b;
            quo_r   <= a;
            rem_r   <= {WIDTH{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          prod_r <= prod_nx_s;
          cnt_r  <= cnt_r - SHW'(1);
          if (cnt_r == {SHW{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_MUL;
          end
        end
        ST_DIV: begin
          quo_r <= quo_nx_s;
          rem_r <= rem_nx_s;
          cnt_r <= cnt_r - SHW'(1);
          if (cnt_r == {SHW{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DIV;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Registered execute-stage ALU with single-cycle logic/arith/shift/compare
// ops and optional multi-cycle multiply/divide behind a start/busy/done
// handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, accepted on a rising edge while busy==0
//   source1, source2  operands A and B, sampled on accept
//   ALU_CTRL          operation code, sampled on accept
//   busy              multi-cycle operation in progress
//   done              one-cycle pulse: result and flags valid
//   result            registered result, held until the next done
//   zero              result == 0
//   illegal           undefined (or disabled) code executed
//   div_by_zero       divide/remainder with source2 == 0
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] source1,
  input  logic [WIDTH-1:0] source2,
  input  logic [3:0]       ALU_CTRL,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept_s;
  logic             b_zero_s;
  logic             iter_go_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_ill_s;
  logic             sc_dbz_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_lo_s;
  logic [WIDTH-1:0] md_hi_s;
  logic [WIDTH-1:0] md_res_s;
  logic             sel_hi_r;

  assign accept_s = start && !busy;
  assign b_zero_s = (source2 == {WIDTH{1'b0}});
  assign shamt_s  = source2[SHW-1:0];
  // Divide by zero never iterates; ALU_CTRL[1] separates DIVU/REMU from MUL/MULHU.
  assign iter_go_s = accept_s && MULDIV_EN && is_muldiv(ALU_CTRL) &&
                     !(ALU_CTRL[1] && b_zero_s);

  // Single-cycle result and flags for the current code.
  always_comb begin
    sc_res_s = {WIDTH{1'b0}};
    sc_ill_s = 1'b0;
    sc_dbz_s = 1'b0;
    case (ALU_CTRL)
      ALU_AND:  sc_res_s = source1 & source2;
      ALU_OR:   sc_res_s = source1 | source2;
      ALU_ADD:  sc_res_s = source1 + source2;
      ALU_XOR:  sc_res_s = source1 ^ source2;
      ALU_SUB:  sc_res_s = source1 - source2;
      ALU_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, (source1 < source2)};
      ALU_SLTS: sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(source1) < $signed(source2))};
      ALU_SLL:  sc_res_s = source1 << shamt_s;
      ALU_SRL:  sc_res_s = source1 >> shamt_s;
      ALU_SRA:  sc_res_s = $signed(source1) >>> shamt_s;
      ALU_MUL, ALU_MULHU: begin
        // With the engine present these always take the iterative path.
        if (MULDIV_EN == 1'b0) begin
          sc_ill_s = 1'b1;
        end else begin
          sc_ill_s = 1'b0;
        end
      end
      ALU_DIVU: begin
        if (MULDIV_EN == 1'b0) begin
          sc_ill_s = 1'b1;
        end else if (b_zero_s) begin
          sc_res_s = {WIDTH{1'b1}};
          sc_dbz_s = 1'b1;
        end else begin
          sc_dbz_s = 1'b0;
        end
      end
      ALU_REMU: begin
        if (MULDIV_EN == 1'b0) begin
          sc_ill_s = 1'b1;
        end else if (b_zero_s) begin
          sc_res_s = source1;
          sc_dbz_s = 1'b1;
        end else begin
          sc_dbz_s = 1'b0;
        end
      end
      default: sc_ill_s = 1'b1;
    endcase
  end

  generate
    if (MULDIV_EN) begin : g_muldiv
      iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (iter_go_s),
        .op    (ALU_CTRL[1]),
        .a     (source1),
        .b     (source2),
        .done  (md_done_s),
        .lo    (md_lo_s),
        .hi    (md_hi_s)
      );
    end else begin : g_no_muldiv
      assign md_done_s = 1'b0;
      assign md_lo_s   = {WIDTH{1'b0}};
      assign md_hi_s   = {WIDTH{1'b0}};
    end
  endgenerate

  // MULHU and REMU (odd codes) return the high half / remainder.
  always_comb begin
    if (sel_hi_r) begin
      md_res_s = md_hi_s;
    end else begin
      md_res_s = md_lo_s;
    end
  end

  // Handshake and result/flag registers; these change only on done edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= {WIDTH{1'b0}};
      zero        <= 1'b1;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
      sel_hi_r    <= 1'b0;
    end else begin
      if (iter_go_s) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        sel_hi_r <= ALU_CTRL[0];
      end else if (accept_s) begin
        result      <= sc_res_s;
        zero        <= (sc_res_s == {WIDTH{1'b0}});
        illegal     <= sc_ill_s;
        div_by_zero <= sc_dbz_s;
        done        <= 1'b1;
      end else if (md_done_s) begin
        result      <= md_res_s;
        zero        <= (md_res_s == {WIDTH{1'b0}});
        illegal     <= 1'b0;
        div_by_zero <= 1'b0;
        done        <= 1'b1;
        busy        <= 1'b0;
      end else begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed cases at WIDTH=16, handshake
// corner cases, and random sweeps at WIDTH=8/16/32 plus MULDIV_EN=0 against
// an arithmetic reference model.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic [3:0]  op_in = 4'd0;
  logic [3:0]  start_v = 4'd0;

  logic [3:0]        busy_v, done_v, zero_v, ill_v, dbz_v;
  logic [3:0][31:0]  res_v;
  logic [7:0]  res8;
  logic [15:0] res16, res_nm;
  logic [31:0] res32;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // sel 0: WIDTH=8, sel 1: WIDTH=16, sel 2: WIDTH=32, sel 3: WIDTH=16 without mul/div
  iter_alu #(.WIDTH(8), .MULDIV_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .source1(a_in[7:0]), .source2(b_in[7:0]),
    .ALU_CTRL(op_in), .busy(busy_v[0]), .done(done_v[0]), .result(res8), .zero(zero_v[0]),
    .illegal(ill_v[0]), .div_by_zero(dbz_v[0]));
  iter_alu #(.WIDTH(16), .MULDIV_EN(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .source1(a_in[15:0]), .source2(b_in[15:0]),
    .ALU_CTRL(op_in), .busy(busy_v[1]), .done(done_v[1]), .result(res16), .zero(zero_v[1]),
    .illegal(ill_v[1]), .div_by_zero(dbz_v[1]));
  iter_alu #(.WIDTH(32), .MULDIV_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .source1(a_in), .source2(b_in),
    .ALU_CTRL(op_in), .busy(busy_v[2]), .done(done_v[2]), .result(res32), .zero(zero_v[2]),
    .illegal(ill_v[2]), .div_by_zero(dbz_v[2]));
  iter_alu #(.WIDTH(16), .MULDIV_EN(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .source1(a_in[15:0]), .source2(b_in[15:0]),
    .ALU_CTRL(op_in), .busy(busy_v[3]), .done(done_v[3]), .result(res_nm), .zero(zero_v[3]),
    .illegal(ill_v[3]), .div_by_zero(dbz_v[3]));

  assign res_v[0] = {24'd0, res8};
  assign res_v[1] = {16'd0, res16};
  assign res_v[2] = res32;
  assign res_v[3] = {16'd0, res_nm};

  typedef struct {
    logic [31:0] r;
    logic        ill;
    logic        dbz;
    logic        iter;
  } exp_t;

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : (sel == 2) ? 32 : 16;
  endfunction

  // Reference model: the operation rules written as plain wide arithmetic.
  function automatic exp_t model(input int w, input bit md, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] m, ua, ub, r, p;
    longint sa, sb;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = longint'(ua);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    sb = longint'(ub);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    sh = int'(ub % 64'(w));
    p  = ua * ub;
    r = 64'd0; e.ill = 1'b0; e.dbz = 1'b0; e.iter = 1'b0;
    case (op)
      4'd0:  r = ua & ub;
      4'd1:  r = ua | ub;
      4'd2:  r = (ua + ub) & m;
      4'd3:  r = ua ^ ub;
      4'd6:  r = (ua - ub) & m;
      4'd7:  r = (ua < ub) ? 64'd1 : 64'd0;
      4'd11: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  r = (ua << sh) & m;
      4'd9:  r = ua >> sh;
      4'd10: r = 64'(sa >>> sh) & m;
      4'd12: if (md) begin r = p & m; e.iter = 1'b1; end else e.ill = 1'b1;
      4'd13: if (md) begin r = (p >> w) & m; e.iter = 1'b1; end else e.ill = 1'b1;
      4'd14: if (!md) e.ill = 1'b1;
             else if (ub == 64'd0) begin r = m; e.dbz = 1'b1; end
             else begin r = ua / ub; e.iter = 1'b1; end
      4'd15: if (!md) e.ill = 1'b1;
             else if (ub == 64'd0) begin r = ua; e.dbz = 1'b1; end
             else begin r = ua % ub; e.iter = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    e.r = r[31:0];
    return e;
  endfunction

  // Issue one op to instance sel; off = negedges after the accept edge until done.
  task automatic run_op(input int sel, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic zr,
                        output logic ill, output logic dbz, output int off, output int bcnt);
    @(negedge clk);
    a_in = a; b_in = b; op_in = op;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v = 4'd0;
    off = 0; bcnt = 0; res = 32'd0; zr = 1'b0; ill = 1'b0; dbz = 1'b0;
    while (done_v[sel] !== 1'b1 && off < 100) begin
      if (busy_v[sel] === 1'b1) bcnt++;
      @(negedge clk);
      off++;
    end
    n_cmp++;
    if (off >= 100) begin
      n_fail++;
      $display("FAIL done_timeout sel=%0d op=%b: got no done in 100 cycles, expected done", sel, op);
      off = -1;
    end else begin
      res = res_v[sel]; zr = zero_v[sel]; ill = ill_v[sel]; dbz = dbz_v[sel];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_v = 4'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (res_v[s] !== 32'd0 || zero_v[s] !== 1'b1 || busy_v[s] !== 1'b0 ||
          done_v[s] !== 1'b0 || ill_v[s] !== 1'b0 || dbz_v[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset sel=%0d: got res=%h z=%b busy=%b done=%b ill=%b dbz=%b, expected 0 1 0 0 0 0",
                 s, res_v[s], zero_v[s], busy_v[s], done_v[s], ill_v[s], dbz_v[s]);
      end
    end
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        ill;
    logic        dbz;
    logic        iter;
  } dvec_t;

  task automatic test_directed16();
    dvec_t tbl [18];
    logic [31:0] res; logic zr, ill, dbz; int off, bcnt, exp_off;
    tbl[0]  = '{4'b0010, 16'd5,      16'd7,      16'h000C, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0110, 16'd5,      16'd7,      16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0111, 16'd5,      16'd7,      16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0111, 16'hFFFF,   16'd1,      16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b1011, 16'hFFFF,   16'd1,      16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0110, 16'd9,      16'd9,      16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b1010, 16'h8000,   16'd3,      16'hF000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b1001, 16'h8000,   16'h0013,   16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b1000, 16'h0001,   16'd15,     16'h8000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b0100, 16'h1234,   16'h0F0F,   16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{4'b0101, 16'h1234,   16'h0F0F,   16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'b1100, 16'd300,    16'd300,    16'h5F90, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{4'b1101, 16'd300,    16'd300,    16'h0001, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{4'b1101, 16'hFFFF,   16'hFFFF,   16'hFFFE, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{4'b1110, 16'd100,    16'd7,      16'd14,   1'b0, 1'b0, 1'b1};
    tbl[15] = '{4'b1111, 16'd100,    16'd7,      16'd2,    1'b0, 1'b0, 1'b1};
    tbl[16] = '{4'b1110, 16'd100,    16'd0,      16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{4'b1111, 16'd100,    16'd0,      16'd100,  1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 18; i++) begin
      run_op(1, tbl[i].op, {16'd0, tbl[i].a}, {16'd0, tbl[i].b}, res, zr, ill, dbz, off, bcnt);
      exp_off = tbl[i].iter ? 16 : 0;
      n_cmp++;
      if (res[15:0] !== tbl[i].r || zr !== (tbl[i].r == 16'd0)) begin
        n_fail++;
        $display("FAIL dir%0d_result op=%b: got %h zero=%b, expected %h zero=%b",
                 i, tbl[i].op, res[15:0], zr, tbl[i].r, (tbl[i].r == 16'd0));
      end
      n_cmp++;
      if (ill !== tbl[i].ill || dbz !== tbl[i].dbz) begin
        n_fail++;
        $display("FAIL dir%0d_flags: got ill=%b dbz=%b, expected ill=%b dbz=%b",
                 i, ill, dbz, tbl[i].ill, tbl[i].dbz);
      end
      n_cmp++;
      if (off !== exp_off || bcnt !== exp_off) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got done after %0d edges busy %0d cycles, expected %0d and %0d",
                 i, off, bcnt, exp_off, exp_off);
      end
      @(negedge clk);
      n_cmp++;
      if (done_v[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_pulse: got done=%b a cycle later, expected 0", i, done_v[1]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dcount = 0; int dk = -1; logic [31:0] dres = 32'd0;
    @(negedge clk);
    a_in = 32'd300; b_in = 32'd300; op_in = 4'b1100; start_v[1] = 1'b1;
    @(negedge clk);
    start_v = 4'd0;
    for (int k = 0; k < 30; k++) begin
      if (done_v[1] === 1'b1) begin dcount++; dk = k; dres = res_v[1]; end
      if (k == 2) begin a_in = 32'd1; b_in = 32'd1; op_in = 4'b0010; start_v[1] = 1'b1; end
      if (k == 3) begin start_v = 4'd0; a_in = $urandom; b_in = $urandom; end
      @(negedge clk);
    end
    n_cmp++;
    if (dcount !== 1 || dk !== 16 || dres !== 32'h5F90) begin
      n_fail++;
      $display("FAIL busy_ignore: got %0d dones at edge %0d result %h, expected 1 at 16 result 5f90",
               dcount, dk, dres);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res; logic zr, ill, dbz; int off, bcnt; int dcount = 0;
    run_op(1, 4'b0010, 32'd3, 32'd4, res, zr, ill, dbz, off, bcnt);
    @(negedge clk);
    a_in = 32'd100; b_in = 32'd7; op_in = 4'b1110; start_v[1] = 1'b1;
    @(negedge clk);
    start_v = 4'd0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy_v[1] !== 1'b1 || res_v[1] !== 32'd7) begin
      n_fail++;
      $display("FAIL midop_busy: got busy=%b res=%h, expected 1 and 7", busy_v[1], res_v[1]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || res_v[1] !== 32'd0 || zero_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset: got busy=%b done=%b res=%h zero=%b, expected 0 0 0 1",
               busy_v[1], done_v[1], res_v[1], zero_v[1]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (done_v[1] === 1'b1) dcount++;
      @(negedge clk);
    end
    n_cmp++;
    if (dcount !== 0) begin
      n_fail++;
      $display("FAIL midop_nodone: got %0d dones after abort, expected 0", dcount);
    end
    run_op(1, 4'b0010, 32'd1, 32'd1, res, zr, ill, dbz, off, bcnt);
    n_cmp++;
    if (res !== 32'd2 || off !== 0) begin
      n_fail++;
      $display("FAIL post_reset_add: got %h after %0d edges, expected 2 after 0", res, off);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    @(negedge clk);
    a_in = 32'd5; b_in = 32'd7; op_in = 4'b0010; start_v[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (done_v[1] !== 1'b1 || res_v[1] !== 32'h000C) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b res=%h, expected 1 000c", done_v[1], res_v[1]);
    end
    a_in = 32'h00F0; b_in = 32'h000F; op_in = 4'b0001;
    @(negedge clk);
    start_v = 4'd0;
    n_cmp++;
    if (done_v[1] !== 1'b1 || res_v[1] !== 32'h00FF) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b res=%h, expected 1 00ff", done_v[1], res_v[1]);
    end
    // Start issued in the same cycle that a multiply's done is high.
    a_in = 32'd3; b_in = 32'd5; op_in = 4'b1100; start_v[1] = 1'b1;
    @(negedge clk);
    start_v = 4'd0;
    while (done_v[1] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_cmp++;
    if (k !== 16 || res_v[1] !== 32'd15) begin
      n_fail++;
      $display("FAIL b2b_mul: got res=%h after %0d edges, expected 000f after 16", res_v[1], k);
    end
    a_in = 32'd2; b_in = 32'd2; op_in = 4'b0010; start_v[1] = 1'b1;
    @(negedge clk);
    start_v = 4'd0;
    n_cmp++;
    if (done_v[1] !== 1'b1 || res_v[1] !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_at_done: got done=%b res=%h, expected 1 0004", done_v[1], res_v[1]);
    end
  endtask

  task automatic test_random(input int sel, input bit md, input int n);
    int w; logic [31:0] m, a, b, res; logic zr, ill, dbz; int off, bcnt, exp_off;
    logic [3:0] op; exp_t e;
    w = width_of(sel);
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < n; i++) begin
      op = 4'(i % 16);
      a = $urandom & m;
      b = $urandom & m;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, w + 2)) & m;
        2: a = m;
        default: ;
      endcase
      run_op(sel, op, a, b, res, zr, ill, dbz, off, bcnt);
      e = model(w, md, op, a, b);
      exp_off = e.iter ? w : 0;
      n_cmp++;
      if (res !== e.r || zr !== (e.r == 32'd0)) begin
        n_fail++;
        $display("FAIL rnd_w%0d_result op=%b a=%h b=%h: got %h zero=%b, expected %h zero=%b",
                 w, op, a, b, res, zr, e.r, (e.r == 32'd0));
      end
      n_cmp++;
      if (ill !== e.ill || dbz !== e.dbz) begin
        n_fail++;
        $display("FAIL rnd_w%0d_flags op=%b: got ill=%b dbz=%b, expected ill=%b dbz=%b",
                 w, op, ill, dbz, e.ill, e.dbz);
      end
      n_cmp++;
      if (off !== exp_off || bcnt !== exp_off) begin
        n_fail++;
        $display("FAIL rnd_w%0d_latency op=%b: got done after %0d busy %0d, expected %0d and %0d",
                 w, op, off, bcnt, exp_off, exp_off);
      end
    end
  endtask

  task automatic test_no_muldiv();
    logic [31:0] res; logic zr, ill, dbz; int off, bcnt;
    for (int c = 12; c < 16; c++) begin
      run_op(3, 4'(c), 32'd100, 32'd7, res, zr, ill, dbz, off, bcnt);
      n_cmp++;
      if (ill !== 1'b1 || res !== 32'd0 || dbz !== 1'b0 || off !== 0 || bcnt !== 0) begin
        n_fail++;
        $display("FAIL nomd_code%0d: got ill=%b res=%h dbz=%b off=%0d busy=%0d, expected 1 0 0 0 0",
                 c, ill, res, dbz, off, bcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed16();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random(0, 1'b1, 48);
    test_random(1, 1'b1, 48);
    test_random(2, 1'b1, 48);
    test_no_muldiv();
    test_random(3, 1'b0, 32);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
